ab_split_using_fifos: RTL

Stream splitter: one valid/ready input stream carries packed `{a, b}` pairs, and the block splits each pair into two independent valid/ready output streams. Each output branch is buffered by its own flop-based FIFO, so a stalled consumer on one branch does not block the other until that branch's FIFO fills. It is the fork counterpart of the a+b join stage and sits where an operand-pair producer feeds two separately-paced consumers.

---
 rtl/ab_split_pkg.sv | 19 +
 rtl/ab_split_fifo.sv | 73 +++++++
 rtl/ab_split_using_fifos.sv | 91 +++++++++
 3 files changed

// File: rtl/ab_split_pkg.sv
// Shared sizing helpers and in_data half-select constants for the a/b stream splitter.
// Used by the branch FIFO and the fork top; no logic of its own.
package ab_split_pkg;

    // Half index within in_data: upper half carries a, lower half carries b.
    localparam int A_HALF = 1;
    localparam int B_HALF = 0;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer addresses 0..depth-1; depth >= 2 keeps this at least 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ab_split_fifo.sv
// Flop-based branch FIFO: 1-cycle write-to-head latency, no bypass, any depth >= 2.
// Backpressure: up_ready drops only when count reaches depth; pop while full frees a slot for the next cycle.
module ab_split_fifo
    import ab_split_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [width-1:0] down_data
);

    localparam int CW = cnt_w(depth);
    localparam int PW = ptr_w(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [width-1:0] mem_q [depth];
    logic             push, pop;

    assign up_ready   = (count_q != FULL_CNT);
    assign down_valid = (count_q != '0);
    assign down_data  = mem_q[rd_ptr_q];

    assign push = up_valid & up_ready;
    assign pop  = down_valid & down_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left out of reset; down_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up_data;
        end
    end

endmodule

// File: rtl/ab_split_using_fifos.sv
// Splits {a,b} pairs into two independently paced streams, each behind its own FIFO; 1-cycle latency.
// Backpressure: lockstep fork stalls input unless both FIFOs have room; AB_SPLIT_EAGER_FORK_EN lets each branch take its copy early.
module ab_split_using_fifos
    import ab_split_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*width-1:0] in_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [width-1:0]   a_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [width-1:0]   b_data
);

    logic a_up_rdy, b_up_rdy;
    logic a_push, b_push;

`ifdef AB_SPLIT_EAGER_FORK_EN
    logic a_done_q, a_done_d;
    logic b_done_q, b_done_d;
    logic in_hs;

    // A branch that already holds its copy of the current pair no longer gates acceptance.
    assign in_ready = (a_done_q | a_up_rdy) & (b_done_q | b_up_rdy);
    assign in_hs    = in_valid & in_ready;
    assign a_push   = in_valid & ~a_done_q & a_up_rdy;
    assign b_push   = in_valid & ~b_done_q & b_up_rdy;

    always_comb begin
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        if (in_hs) begin
            a_done_d = 1'b0;
            b_done_d = 1'b0;
        end else begin
            a_done_d = a_done_q | a_push;
            b_done_d = b_done_q | b_push;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
        end
    end
`else
    assign in_ready = a_up_rdy & b_up_rdy;
    assign a_push   = in_valid & in_ready;
    assign b_push   = in_valid & in_ready;
`endif

    ab_split_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo_a (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (a_push),
        .up_ready   (a_up_rdy),
        .up_data    (in_data[A_HALF*width +: width]),
        .down_valid (a_valid),
        .down_ready (a_ready),
        .down_data  (a_data)
    );

    ab_split_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo_b (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (b_push),
        .up_ready   (b_up_rdy),
        .up_data    (in_data[B_HALF*width +: width]),
        .down_valid (b_valid),
        .down_ready (b_ready),
        .down_data  (b_data)
    );

endmodule
